// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-requester SRAM port arbiter.
//   NUM_REQ         number of requesters sharing the controller port
//   DEF_*_WIDTH     default address/data widths for the arbiter
//   arb_state_e     arbiter FSM states
package sram_arb_pkg;

   localparam int NUM_REQ        = 2;
   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEF_DATA_WIDTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } arb_state_e;

endpackage

// File: rtl/sram_rr_pick.sv
// Two-way round-robin pick.
//   req     request vector, bit i = requester i
//   last    index of the requester granted last
//   any     at least one request present
//   winner  selected requester (meaningful only when any = 1)
module sram_rr_pick
   import sram_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic               last,
   output logic               any,
   output logic               winner
);

   always_comb begin
      any    = |req;
      winner = 1'b0;
      if (req == 2'b11)
         winner = ~last;      // tie: the one not served last time
      else if (req[1])
         winner = 1'b1;       // lone request wins outright
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates two requesters onto a single SRAM controller CPU port.
//   clk, reset        clock, synchronous active-low reset
//   m_req/m_rw/...    per-requester request, direction (1=read), address, write data
//   m_rdata           shared read data, valid with m_done
//   m_done/m_err      one-cycle completion pulse and timeout flag to the granted requester
//   ctl_*             latched request to the controller; ctl_ready/ctl_rdata come back
//   busy, grant_id    arbiter activity and requester currently serviced
// All outputs are registered; the comb process computes next values for every register.
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            m_req,
   input  logic [NUM_REQ-1:0]            m_rw,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] m_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] m_wdata,
   output logic [DATA_WIDTH-1:0]         m_rdata,
   output logic [NUM_REQ-1:0]            m_done,
   output logic [NUM_REQ-1:0]            m_err,
   output logic                          ctl_req,
   output logic                          ctl_rw,
   output logic [ADDR_WIDTH-1:0]         ctl_addr,
   output logic [DATA_WIDTH-1:0]         ctl_wdata,
   input  logic [DATA_WIDTH-1:0]         ctl_rdata,
   input  logic                          ctl_ready,
   output logic                          busy,
   output logic                          grant_id
);

   localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   arb_state_e             state, state_n;
   logic [CNT_W-1:0]       cnt, cnt_n;
   logic                   last, last_n;
   logic                   pick_any, pick_winner;

   logic                   ctl_req_n, ctl_rw_n, busy_n, grant_n;
   logic [ADDR_WIDTH-1:0]  ctl_addr_n;
   logic [DATA_WIDTH-1:0]  ctl_wdata_n, m_rdata_n;
   logic [NUM_REQ-1:0]     m_done_n, m_err_n;

   sram_rr_pick u_pick (
      .req    (m_req),
      .last   (last),
      .any    (pick_any),
      .winner (pick_winner)
   );

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      last_n      = last;
      ctl_req_n   = ctl_req;
      ctl_rw_n    = ctl_rw;
      ctl_addr_n  = ctl_addr;
      ctl_wdata_n = ctl_wdata;
      m_rdata_n   = m_rdata;
      grant_n     = grant_id;
      m_done_n    = '0;
      m_err_n     = '0;

      case (state)
         ST_IDLE: begin
            if (pick_any) begin
               state_n     = ST_ISSUE;
               grant_n     = pick_winner;
               last_n      = pick_winner;
               ctl_req_n   = 1'b1;
               ctl_rw_n    = m_rw[pick_winner];
               ctl_addr_n  = pick_winner ? m_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                         : m_addr[ADDR_WIDTH-1:0];
               ctl_wdata_n = pick_winner ? m_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                         : m_wdata[DATA_WIDTH-1:0];
            end
         end
         ST_ISSUE: begin
            state_n = ST_WAIT;
            cnt_n   = '0;
         end
         ST_WAIT: begin
            // ready is checked first so a same-cycle timeout still completes normally
            if (ctl_ready) begin
               state_n            = ST_RESP;
               ctl_req_n          = 1'b0;
               m_done_n[grant_id] = 1'b1;
               if (ctl_rw)
                  m_rdata_n = ctl_rdata;
            end else if (cnt == CNT_LAST) begin
               state_n            = ST_RESP;
               ctl_req_n          = 1'b0;
               m_rdata_n          = '0;
               m_done_n[grant_id] = 1'b1;
               m_err_n[grant_id]  = 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         ST_RESP: begin
            state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase

      busy_n = (state_n != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         last      <= 1'b1;
         ctl_req   <= 1'b0;
         ctl_rw    <= 1'b0;
         ctl_addr  <= '0;
         ctl_wdata <= '0;
         m_rdata   <= '0;
         m_done    <= '0;
         m_err     <= '0;
         busy      <= 1'b0;
         grant_id  <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         last      <= last_n;
         ctl_req   <= ctl_req_n;
         ctl_rw    <= ctl_rw_n;
         ctl_addr  <= ctl_addr_n;
         ctl_wdata <= ctl_wdata_n;
         m_rdata   <= m_rdata_n;
         m_done    <= m_done_n;
         m_err     <= m_err_n;
         busy      <= busy_n;
         grant_id  <= grant_n;
      end
   end

endmodule
